// File: rtl/inst_fetch_pkg.sv
// Shared types and default widths for the instruction fetch controller.
package inst_fetch_pkg;

    localparam int DEF_DATA_W = 9;
    localparam int DEF_ADDR_W = 7;

    // Controller modes
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2
    } fetch_state_t;

    // One output-buffer slot: the fetched word and the address it came from
    typedef struct packed {
        logic [DEF_DATA_W-1:0] word;
        logic [DEF_ADDR_W-1:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction stream from the fetch controller to the decoder.
// Handshake: a beat transfers in every cycle where instr_valid and instr_ready
// are both high; while instr_valid is high and instr_ready is low the producer
// holds instr and instr_pc stable and may not drop instr_valid except on a
// flush (jump or stop); instr_valid never waits on instr_ready.
interface inst_fetch_if
    import inst_fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-slot output buffer holding fetched {word, pc} pairs, with a
// single-cycle flush that empties it regardless of push/pop.
module fetch_fifo
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        push_i,
    input  fifo_entry_t push_entry_i,
    input  logic        pop_i,
    output fifo_entry_t head_o,
    output logic [1:0]  count_o
);

    fifo_entry_t slot_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        do_push;
    logic        do_pop;

    // Push into a full buffer or pop from an empty one is ignored
    assign do_push = push_i && !flush_i && (count_q != 2'd2);
    assign do_pop  = pop_i  && !flush_i && (count_q != 2'd0);

    // Slot storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_o  = slot_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction memory initiator: loads the memory from a word stream and
// streams instructions out with a two-deep prefetch buffer and jump support.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RESET_PC = 0
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              start,
    input  logic              stop,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    inst_fetch_if.master      instr_if,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   load_count,
    output fetch_state_t      dbg_state
);

    localparam logic [ADDR_W:0]   LOAD_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              flush;
    logic              push;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [2:0]        credit_used;
    fifo_entry_t       head;
    fifo_entry_t       push_entry;

    assign pop         = instr_if.instr_valid & instr_if.instr_ready;
    // Slots already claimed once this cycle's pop is taken into account
    assign credit_used = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

    assign push_entry.word = mem_rdata;
    assign push_entry.pc   = inflight_pc_q;

    // Mode, counters and in-flight read tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= PC_RESET;
            load_ptr_q    <= '0;
            load_count_q  <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            load_ptr_q    <= load_ptr_d;
            load_count_q  <= load_count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Next-state, read issue and memory pin muxing
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        load_ptr_d    = load_ptr_q;
        load_count_d  = load_count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        issue         = 1'b0;
        issue_addr    = '0;
        flush         = 1'b0;
        push          = 1'b0;
        mem_we        = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d      = LOAD;
                    load_ptr_d   = '0;
                    load_count_d = '0;
                end else if (start) begin
                    // The first read of RESET_PC goes out in the start cycle
                    // itself so the first instruction shows two cycles later.
                    state_d    = FETCH;
                    issue      = 1'b1;
                    issue_addr = PC_RESET;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    mem_we     = 1'b1;
                    load_ptr_d = load_ptr_q + ADDR_W'(1);
                    if (load_count_q != LOAD_MAX) begin
                        load_count_d = load_count_q + (ADDR_W + 1)'(1);
                    end
                end
                if (!load_en) begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (stop) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (jump_en) begin
                    flush      = 1'b1;
                    issue      = 1'b1;
                    issue_addr = jump_addr;
                end else begin
                    push = inflight_q;
                    if (credit_used < 3'd2) begin
                        issue      = 1'b1;
                        issue_addr = pc_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            pc_d          = issue_addr + ADDR_W'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = issue_addr;
        end

        mem_addr  = mem_we ? load_ptr_q : (issue ? issue_addr : '0);
        mem_wdata = mem_we ? load_data : '0;
    end

    fetch_fifo u_fifo (
        .clk          (clk),
        .rst_n        (reset_n),
        .flush_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (fifo_count)
    );

    assign instr_if.instr_valid = (fifo_count != 2'd0);
    assign instr_if.instr       = instr_if.instr_valid ? head.word : '0;
    assign instr_if.instr_pc    = instr_if.instr_valid ? head.pc : '0;
    assign load_ready           = (state_q == LOAD);
    assign load_count           = load_count_q;
    assign dbg_state            = state_q;

endmodule
